// File: rtl/nibble_adder_arb_pkg.sv
// Shared constants, ID-width helper and output-register state type for the
// shared nibble adder with round-robin arbitration.
package nibble_adder_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int DW_DEF    = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } res_state_t;

    // A single requester still needs a 1-bit ID field.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_adder_arbiter_rr_arbiter.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping modulo N_REQ. The grant vector is gated by enable; found is not.
module rr_arbiter
    import nibble_adder_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IW    = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             found
);

    logic [IW-1:0] pos_idx;

    // Scan from the farthest offset down so the nearest hit after ptr wins.
    always_comb begin
        idx     = '0;
        found   = 1'b0;
        pos_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos_idx = IW'((int'(ptr) + k) % N_REQ);
            if (req[pos_idx]) begin
                idx   = pos_idx;
                found = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_grant
            assign grant[gi] = enable && found && (idx == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/nibble_adder_arbiter.sv
// One registered DW-bit adder shared by N_REQ requesters through a round-robin
// arbiter and a one-entry result register. NIBBLE_ADDER_ARB_STATS_EN adds grant_cnt.
module nibble_adder_arbiter
    import nibble_adder_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF
`ifdef NIBBLE_ADDER_ARB_STATS_EN
    , parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DW-1:0]         req_a,
    input  logic [N_REQ*DW-1:0]         req_b,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        res_valid,
    output logic [DW:0]                 res_sum,
    output logic [id_width(N_REQ)-1:0]  res_id,
    input  logic                        res_ready
`ifdef NIBBLE_ADDER_ARB_STATS_EN
    , output logic [N_REQ*CNT_W-1:0]    grant_cnt
`endif
);

    localparam int IW = id_width(N_REQ);

    res_state_t    state_reg;
    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] win_idx;
    logic          win_found;
    logic          can_accept;
    logic          accept;
    logic [N_REQ-1:0] grant;
    logic [DW-1:0] a_arr [N_REQ];
    logic [DW-1:0] b_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign a_arr[gi] = req_a[gi*DW +: DW];
            assign b_arr[gi] = req_b[gi*DW +: DW];
        end
    endgenerate

    // Gating with rst_n drops req_ready immediately while reset is held.
    assign can_accept = rst_n && ((state_reg == EMPTY) || res_ready);

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_reg),
        .enable (can_accept),
        .grant  (grant),
        .idx    (win_idx),
        .found  (win_found)
    );

    assign req_ready = grant;
    assign accept    = can_accept && win_found;
    assign res_valid = (state_reg == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            ptr_reg   <= '0;
            res_sum   <= '0;
            res_id    <= '0;
        end else if (accept) begin
            res_sum   <= {1'b0, a_arr[win_idx]} + {1'b0, b_arr[win_idx]};
            res_id    <= win_idx;
            state_reg <= FULL;
            ptr_reg   <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end else if ((state_reg == FULL) && res_ready) begin
            state_reg <= EMPTY;
        end
    end

`ifdef NIBBLE_ADDER_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_reg [N_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) cnt_reg[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i] && (cnt_reg[i] != '1)) cnt_reg[i] <= cnt_reg[i] + 1'b1;
            end
        end
    end

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cnt
            assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_reg[gi];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_nibble_adder_arbiter.sv
// Table-driven bench for nibble_adder_arbiter plus hand sequences for
// backpressure, asynchronous reset and the optional grant counters.
module tb_nibble_adder_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [4:0]  res_sum;
    logic [1:0]  res_id;
    logic        res_ready;
`ifdef NIBBLE_ADDER_ARB_STATS_EN
    logic [31:0] grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    nibble_adder_arbiter #(.N_REQ(4), .DW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .res_ready (res_ready)
`ifdef NIBBLE_ADDER_ARB_STATS_EN
        , .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] a;
        logic [15:0] b;
        logic        rr;
        logic [3:0]  ready;
        logic        rv;
        logic [4:0]  sum;
        logic [1:0]  id;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // Per-requester operands when all four are valid: sums 8, B, 4, 1E.
        vecs[0]  = '{4'b0001, 16'h0003, 16'h0004, 1'b1, 4'b0001, 1'b1, 5'h07, 2'd0};
        vecs[1]  = '{4'b1111, 16'hF321, 16'hF197, 1'b1, 4'b0010, 1'b1, 5'h0B, 2'd1};
        vecs[2]  = '{4'b1111, 16'hF321, 16'hF197, 1'b1, 4'b0100, 1'b1, 5'h04, 2'd2};
        vecs[3]  = '{4'b1111, 16'hF321, 16'hF197, 1'b1, 4'b1000, 1'b1, 5'h1E, 2'd3};
        vecs[4]  = '{4'b1111, 16'hF321, 16'hF197, 1'b1, 4'b0001, 1'b1, 5'h08, 2'd0};
        vecs[5]  = '{4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 5'h08, 2'd0};
        vecs[6]  = '{4'b0001, 16'h000F, 16'h0001, 1'b1, 4'b0001, 1'b1, 5'h10, 2'd0};
        vecs[7]  = '{4'b1000, 16'hF000, 16'hF000, 1'b0, 4'b0000, 1'b1, 5'h10, 2'd0};
        vecs[8]  = '{4'b1000, 16'hF000, 16'hF000, 1'b1, 4'b1000, 1'b1, 5'h1E, 2'd3};
        vecs[9]  = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 5'h1E, 2'd3};
        vecs[10] = '{4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 5'h1E, 2'd3};

        rst_n = 1'b0;
        req_valid = 4'b1111;
        req_a = 16'h0;
        req_b = 16'h0;
        res_ready = 1'b1;
        #3;
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_res_valid", 32'(res_valid), 32'h0);
        check("reset_res_sum",   32'(res_sum),   32'h0);
        check("reset_res_id",    32'(res_id),    32'h0);
        req_valid = 4'b0000;
        repeat (2) @(posedge clk);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            req_valid = vecs[i].valid;
            req_a     = vecs[i].a;
            req_b     = vecs[i].b;
            res_ready = vecs[i].rr;
            #2;
            check("vec_req_ready", 32'(req_ready), 32'(vecs[i].ready));
            @(posedge clk);
            #1;
            check("vec_res_valid", 32'(res_valid), 32'(vecs[i].rv));
            check("vec_res_sum",   32'(res_sum),   32'(vecs[i].sum));
            check("vec_res_id",    32'(res_id),    32'(vecs[i].id));
            $display("vec %0d: valid=%b rr=%b ready=%b -> res_valid=%b sum=%h id=%0d",
                     i, vecs[i].valid, vecs[i].rr, vecs[i].ready, res_valid, res_sum, res_id);
        end

        // Backpressure: fill, hold for 3 cycles with 1 and 2 waiting, then release.
        req_a = 16'h0752;
        req_b = 16'h0962;
        req_valid = 4'b0001;
        res_ready = 1'b0;
        #2 check("bp_fill_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        check("bp_fill_sum", 32'(res_sum), 32'h04);
        $display("bp fill: sum=%h id=%0d", res_sum, res_id);
        req_valid = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            #2 check("bp_hold_ready", 32'(req_ready), 32'h0);
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(res_valid), 32'h1);
            check("bp_hold_sum",   32'(res_sum),   32'h04);
            check("bp_hold_id",    32'(res_id),    32'h0);
            $display("bp hold %0d: ready=%b sum=%h id=%0d", c, req_ready, res_sum, res_id);
        end
        res_ready = 1'b1;
        #2 check("bp_release_ready", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        check("bp_release_sum", 32'(res_sum), 32'h0B);
        check("bp_release_id",  32'(res_id),  32'h1);
        $display("bp release: sum=%h id=%0d", res_sum, res_id);
        req_valid = 4'b0100;
        #2 check("bp_next_ready", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        check("bp_next_sum", 32'(res_sum), 32'h10);
        check("bp_next_id",  32'(res_id),  32'h2);
        $display("bp next: sum=%h id=%0d", res_sum, res_id);

        // Asynchronous reset while FULL with requests pending (ptr is at 3).
        req_valid = 4'b1111;
        req_a = 16'hF321;
        req_b = 16'hF197;
        res_ready = 1'b0;
        #2 check("rst_pre_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(res_valid), 32'h0);
        check("rst_mid_ready", 32'(req_ready), 32'h0);
        check("rst_mid_sum",   32'(res_sum),   32'h0);
        check("rst_mid_id",    32'(res_id),    32'h0);
        #1 rst_n = 1'b1;
        res_ready = 1'b1;
        #1 check("rst_post_ready", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        check("rst_post_id",  32'(res_id),  32'h0);
        check("rst_post_sum", 32'(res_sum), 32'h08);
        $display("reset recovery: first grant id=%0d sum=%h", res_id, res_sum);

`ifdef NIBBLE_ADDER_ARB_STATS_EN
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        req_valid = 4'b0100;
        res_ready = 1'b1;
        repeat (300) @(posedge clk);
        #1 req_valid = 4'b0000;
        check("cnt_req0", 32'(grant_cnt[7:0]),   32'd0);
        check("cnt_req1", 32'(grant_cnt[15:8]),  32'd0);
        check("cnt_req2", 32'(grant_cnt[23:16]), 32'd255);
        check("cnt_req3", 32'(grant_cnt[31:24]), 32'd0);
        $display("stats: grant_cnt=%h", grant_cnt);
`endif

        req_valid = 4'b0000;
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
